// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_pkg
// Purpose  : Shared types and constants for the Edwards-curve scalar ladder.
// Revision : 1.0  initial parametrised ladder release
// ============================================================================
package ecc_pkg;

  // Ladder sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DBL_WAIT = 2'd1,
    ADD_WAIT = 2'd2,
    DONE     = 2'd3
  } ladder_state_t;

  // Projective identity point (0 : 1 : 1)
  localparam int ID_X = 0;
  localparam int ID_Y = 1;
  localparam int ID_Z = 1;

  // Bit-counter width for an n-bit scalar; never narrower than one bit
  function automatic int cnt_width(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

  // Counter width for the default 255-bit scalar
  localparam int CNT_W = cnt_width(255);

endpackage
`default_nettype wire

// File: rtl/scalar_mul_ladder_operand_mux.sv
`default_nettype none
// ============================================================================
// Module   : ladder_operand_mux
// Purpose  : Registered issue stage towards the point-add unit. Captures the
//            double or add operands together with a one-cycle start pulse and
//            holds them stable until the next issue.
// Revision : 1.0  initial release
// ============================================================================
module ladder_operand_mux #(
  parameter int WIDTH = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic             sel_add_i,
  input  logic [WIDTH-1:0] acc_x_i,
  input  logic [WIDTH-1:0] acc_y_i,
  input  logic [WIDTH-1:0] acc_z_i,
  input  logic [WIDTH-1:0] p_x_i,
  input  logic [WIDTH-1:0] p_y_i,
  input  logic [WIDTH-1:0] p_z_i,
  output logic             pa_start_o,
  output logic [WIDTH-1:0] pa_x1_o,
  output logic [WIDTH-1:0] pa_y1_o,
  output logic [WIDTH-1:0] pa_z1_o,
  output logic [WIDTH-1:0] pa_x2_o,
  output logic [WIDTH-1:0] pa_y2_o,
  output logic [WIDTH-1:0] pa_z2_o
);

  // Load operands with the start pulse; operand 2 is P for an add, else the accumulator
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pa_start_o <= 1'b0;
      pa_x1_o    <= '0;
      pa_y1_o    <= '0;
      pa_z1_o    <= '0;
      pa_x2_o    <= '0;
      pa_y2_o    <= '0;
      pa_z2_o    <= '0;
    end else begin
      pa_start_o <= issue_i;
      if (issue_i) begin
        pa_x1_o <= acc_x_i;
        pa_y1_o <= acc_y_i;
        pa_z1_o <= acc_z_i;
        pa_x2_o <= sel_add_i ? p_x_i : acc_x_i;
        pa_y2_o <= sel_add_i ? p_y_i : acc_y_i;
        pa_z2_o <= sel_add_i ? p_z_i : acc_z_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/scalar_mul_ladder.sv
`default_nettype none
// ============================================================================
// Module   : scalar_mul_ladder
// Purpose  : R = M*P on a twisted-Edwards curve, MSB-first double-and-add
//            (optionally double-and-always-add) driving an external point-add
//            unit through a start/finished handshake.
// Revision : 1.0  parametrised successor with CT mode, abort and busy/valid
// ============================================================================
module scalar_mul_ladder
  import ecc_pkg::*;
#(
  parameter int WIDTH   = 255,
  parameter int NBITS   = 255,
  parameter int CT_MODE = 0,
  parameter int PA_ID_Z = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [NBITS-1:0] i_M,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic [WIDTH-1:0] o_z,
  output logic             o_pa_start,
  output logic [WIDTH-1:0] o_pa_x1,
  output logic [WIDTH-1:0] o_pa_y1,
  output logic [WIDTH-1:0] o_pa_z1,
  output logic [WIDTH-1:0] o_pa_x2,
  output logic [WIDTH-1:0] o_pa_y2,
  output logic [WIDTH-1:0] o_pa_z2,
  input  logic [WIDTH-1:0] i_pa_x3,
  input  logic [WIDTH-1:0] i_pa_y3,
  input  logic [WIDTH-1:0] i_pa_z3,
  input  logic             i_pa_finished
);

  localparam int              CW        = cnt_width(NBITS);
  localparam logic [CW-1:0]   c_cnt_top = CW'(NBITS - 1);
  localparam logic [WIDTH-1:0] c_id_x   = WIDTH'(ID_X);
  localparam logic [WIDTH-1:0] c_id_y   = WIDTH'(ID_Y);
  localparam logic [WIDTH-1:0] c_id_z   = WIDTH'(ID_Z);
  localparam logic [WIDTH-1:0] c_p_z    = WIDTH'(PA_ID_Z);

  ladder_state_t    state_q, state_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [WIDTH-1:0] px_q, px_d, py_q, py_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] accx_q, accx_d, accy_q, accy_d, accz_q, accz_d;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic             w_issue, w_sel_add, w_bit, w_last;

  assign w_bit  = m_q[cnt_q];
  assign w_last = (cnt_q == '0);

  // Sequencing decisions: next state, accumulator update and issue requests.
  // The accumulator's next value feeds the issue stage so a new request always
  // sees the freshly written result (or the identity on a start).
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    px_d      = px_q;
    py_d      = py_q;
    cnt_d     = cnt_q;
    accx_d    = accx_q;
    accy_d    = accy_q;
    accz_d    = accz_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    w_issue   = 1'b0;
    w_sel_add = 1'b0;
    if (i_abort) begin
      // Abort wins over everything, including a start in IDLE
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            m_d     = i_M;
            px_d    = i_x;
            py_d    = i_y;
            accx_d  = c_id_x;
            accy_d  = c_id_y;
            accz_d  = c_id_z;
            cnt_d   = c_cnt_top;
            busy_d  = 1'b1;
            w_issue = 1'b1;
            state_d = DBL_WAIT;
          end
        end
        DBL_WAIT: begin
          if (i_pa_finished) begin
            accx_d = i_pa_x3;
            accy_d = i_pa_y3;
            accz_d = i_pa_z3;
            if ((CT_MODE != 0) || w_bit) begin
              w_issue   = 1'b1;
              w_sel_add = 1'b1;
              state_d   = ADD_WAIT;
            end else if (w_last) begin
              state_d = DONE;
            end else begin
              cnt_d   = cnt_q - 1'b1;
              w_issue = 1'b1;
              state_d = DBL_WAIT;
            end
          end
        end
        ADD_WAIT: begin
          if (i_pa_finished) begin
            // In constant-time mode the add for a zero bit is simply dropped
            if (w_bit) begin
              accx_d = i_pa_x3;
              accy_d = i_pa_y3;
              accz_d = i_pa_z3;
            end
            if (w_last) begin
              state_d = DONE;
            end else begin
              cnt_d   = cnt_q - 1'b1;
              w_issue = 1'b1;
              state_d = DBL_WAIT;
            end
          end
        end
        DONE: begin
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= c_cnt_top;
      accx_q  <= c_id_x;
      accy_q  <= c_id_y;
      accz_q  <= c_id_z;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cnt_q   <= cnt_d;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      accz_q  <= accz_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  ladder_operand_mux #(
    .WIDTH(WIDTH)
  ) u_opmux (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .issue_i   (w_issue),
    .sel_add_i (w_sel_add),
    .acc_x_i   (accx_d),
    .acc_y_i   (accy_d),
    .acc_z_i   (accz_d),
    .p_x_i     (px_q),
    .p_y_i     (py_q),
    .p_z_i     (c_p_z),
    .pa_start_o(o_pa_start),
    .pa_x1_o   (o_pa_x1),
    .pa_y1_o   (o_pa_y1),
    .pa_z1_o   (o_pa_z1),
    .pa_x2_o   (o_pa_x2),
    .pa_y2_o   (o_pa_y2),
    .pa_z2_o   (o_pa_z2)
  );

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_x     = accx_q;
  assign o_y     = accy_q;
  assign o_z     = accz_q;

endmodule
`default_nettype wire
